// File: rtl/xif_coprocessor_alu.sv
// -----------------------------------------------------------------------------
// xif_coprocessor_alu
//
// Coprocessor-side CV-X-IF endpoint that executes custom-0 ALU instructions
// (ADD, XOR, SUB, AND on two source registers). Each accepted instruction
// takes an in-flight entry that collects operands from the register interface
// and a commit/kill decision from the commit interface. Entries retire strictly
// in issue order from the head: killed entries are dropped silently, committed
// entries with operands present their result until the core takes it.
// The module provides the issue, register, commit and result interfaces only.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   issue_*               instruction offer and combinational accept response
//   register_*            operand delivery (rs0/rs1), matched by {hartid,id}
//   commit_*              commit or kill of an offloaded instruction
//   result_*              in-order result return with valid/ready handshake
// -----------------------------------------------------------------------------
module xif_coprocessor_alu #(
  parameter int X_ID_WIDTH     = 4,
  parameter int X_HARTID_WIDTH = 1,
  parameter int X_RFR_WIDTH    = 32,
  parameter int X_RFW_WIDTH    = 32,
  parameter int DEPTH          = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // issue interface
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [31:0]               issue_instr_i,
  input  logic [X_HARTID_WIDTH-1:0] issue_hartid_i,
  input  logic [X_ID_WIDTH-1:0]     issue_id_i,
  output logic                      issue_accept_o,
  output logic                      issue_writeback_o,
  output logic [1:0]                issue_register_read_o,
  output logic                      issue_ecswrite_o,
  output logic                      issue_loadstore_o,
  // register interface
  input  logic                      register_valid_i,
  output logic                      register_ready_o,
  input  logic [X_HARTID_WIDTH-1:0] register_hartid_i,
  input  logic [X_ID_WIDTH-1:0]     register_id_i,
  input  logic [X_RFR_WIDTH-1:0]    register_rs0_i,
  input  logic [X_RFR_WIDTH-1:0]    register_rs1_i,
  input  logic [1:0]                register_rs_valid_i,
  // commit interface
  input  logic                      commit_valid_i,
  input  logic [X_HARTID_WIDTH-1:0] commit_hartid_i,
  input  logic [X_ID_WIDTH-1:0]     commit_id_i,
  input  logic                      commit_kill_i,
  // result interface
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic [X_HARTID_WIDTH-1:0] result_hartid_o,
  output logic [X_ID_WIDTH-1:0]     result_id_o,
  output logic [X_RFW_WIDTH-1:0]    result_data_o,
  output logic [4:0]                result_rd_o,
  output logic                      result_we_o,
  output logic [2:0]                result_ecswe_o,
  output logic [5:0]                result_ecsdata_o,
  output logic                      result_exc_o,
  output logic                      result_dbg_o,
  output logic                      result_err_o,
  output logic [5:0]                result_exccode_o
);

  localparam int         PTR_W       = $clog2(DEPTH);
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  // In-flight entry storage
  logic [DEPTH-1:0]          r_valid;
  logic [DEPTH-1:0]          r_ops;
  logic [DEPTH-1:0]          r_committed;
  logic [DEPTH-1:0]          r_killed;
  logic [X_HARTID_WIDTH-1:0] r_hartid [DEPTH];
  logic [X_ID_WIDTH-1:0]     r_id     [DEPTH];
  logic [4:0]                r_rd     [DEPTH];
  logic [1:0]                r_op     [DEPTH];
  logic [X_RFR_WIDTH-1:0]    r_rs0    [DEPTH];
  logic [X_RFR_WIDTH-1:0]    r_rs1    [DEPTH];
  logic [PTR_W-1:0]          r_head;
  logic [PTR_W-1:0]          r_tail;
  logic [PTR_W:0]            r_count;

  logic                   w_accept;
  logic                   w_full;
  logic                   w_alloc;
  logic                   w_reg_hs;
  logic                   w_head_kill;
  logic                   w_result_valid;
  logic                   w_pop;
  logic [DEPTH-1:0]       w_alloc_hit;
  logic [DEPTH-1:0]       w_reg_hit;
  logic [DEPTH-1:0]       w_commit_hit;
  logic [DEPTH-1:0]       w_pop_hit;
  logic [X_RFW_WIDTH-1:0] w_alu;
  logic                   w_unused;

  // Decode: custom-0 with funct3 in 000..011 (funct3[2] clear)
  assign w_accept              = (issue_instr_i[6:0] == OPC_CUSTOM0) && !issue_instr_i[14];
  assign issue_accept_o        = w_accept;
  assign issue_writeback_o     = w_accept;
  assign issue_register_read_o = {w_accept, w_accept};
  assign issue_ecswrite_o      = 1'b0;
  assign issue_loadstore_o     = 1'b0;
  assign w_unused              = ^issue_instr_i[31:15];

  // Ready depends only on occupancy, so a same-cycle pop never frees a slot early
  assign w_full           = (r_count == (PTR_W + 1)'(DEPTH));
  assign issue_ready_o    = !w_full && !rst_i;
  assign register_ready_o = !rst_i;
  assign w_alloc          = issue_valid_i && issue_ready_o && w_accept;
  assign w_reg_hs         = register_valid_i && register_ready_o && (register_rs_valid_i == 2'b11);

  // Per-entry match logic. An entry being allocated this cycle is treated as
  // live with the incoming issue fields and clear status bits, so register and
  // commit handshakes in the same cycle as the issue still land on it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic                      w_live;
      logic                      w_ops;
      logic                      w_committed;
      logic [X_HARTID_WIDTH-1:0] w_hartid;
      logic [X_ID_WIDTH-1:0]     w_id;

      assign w_alloc_hit[gi]  = w_alloc && (r_tail == PTR_W'(gi));
      assign w_live           = r_valid[gi] || w_alloc_hit[gi];
      assign w_ops            = w_alloc_hit[gi] ? 1'b0 : r_ops[gi];
      assign w_committed      = w_alloc_hit[gi] ? 1'b0 : r_committed[gi];
      assign w_hartid         = w_alloc_hit[gi] ? issue_hartid_i : r_hartid[gi];
      assign w_id             = w_alloc_hit[gi] ? issue_id_i : r_id[gi];

      assign w_reg_hit[gi]    = w_reg_hs && w_live && !w_ops &&
                                (w_hartid == register_hartid_i) && (w_id == register_id_i);
      assign w_commit_hit[gi] = commit_valid_i && !rst_i && w_live && !w_committed &&
                                (w_hartid == commit_hartid_i) && (w_id == commit_id_i);
      assign w_pop_hit[gi]    = w_pop && (r_head == PTR_W'(gi));
    end
  endgenerate

  // Head retirement
  assign w_head_kill    = r_valid[r_head] && r_committed[r_head] && r_killed[r_head];
  assign w_result_valid = r_valid[r_head] && r_committed[r_head] && !r_killed[r_head] &&
                          r_ops[r_head] && !rst_i;
  assign w_pop          = w_head_kill || (w_result_valid && result_ready_i);

  always_comb begin
    w_alu = '0;
    case (r_op[r_head])
      2'b00:   w_alu = r_rs0[r_head] + r_rs1[r_head];
      2'b01:   w_alu = r_rs0[r_head] ^ r_rs1[r_head];
      2'b10:   w_alu = r_rs0[r_head] - r_rs1[r_head];
      default: w_alu = r_rs0[r_head] & r_rs1[r_head];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc_hit[i]) begin
          r_valid[i]     <= 1'b1;
          r_hartid[i]    <= issue_hartid_i;
          r_id[i]        <= issue_id_i;
          r_rd[i]        <= issue_instr_i[11:7];
          r_op[i]        <= issue_instr_i[13:12];
          r_ops[i]       <= 1'b0;
          r_committed[i] <= 1'b0;
          r_killed[i]    <= 1'b0;
        end
        // Later assignments override the allocation defaults above
        if (w_reg_hit[i]) begin
          r_rs0[i] <= register_rs0_i;
          r_rs1[i] <= register_rs1_i;
          r_ops[i] <= 1'b1;
        end
        if (w_commit_hit[i]) begin
          r_committed[i] <= 1'b1;
          r_killed[i]    <= commit_kill_i;
        end
        if (w_pop_hit[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_alloc) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_alloc && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_alloc && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Result fields are forced to zero whenever no result is offered
  assign result_valid_o   = w_result_valid;
  assign result_we_o      = w_result_valid;
  assign result_hartid_o  = w_result_valid ? r_hartid[r_head] : '0;
  assign result_id_o      = w_result_valid ? r_id[r_head] : '0;
  assign result_rd_o      = w_result_valid ? r_rd[r_head] : '0;
  assign result_data_o    = w_result_valid ? w_alu : '0;
  assign result_ecswe_o   = '0;
  assign result_ecsdata_o = '0;
  assign result_exc_o     = 1'b0;
  assign result_dbg_o     = 1'b0;
  assign result_err_o     = 1'b0;
  assign result_exccode_o = '0;

endmodule

// File: tb/tb_xif_coprocessor_alu.sv
// -----------------------------------------------------------------------------
// tb_xif_coprocessor_alu
//
// Directed bench for xif_coprocessor_alu: a decode table, an ALU table with
// issue/register/commit in one cycle, and hand sequences for reject, kill
// ordering, full/wrap, out-of-order operands and reset mid-flight.
// -----------------------------------------------------------------------------
module tb_xif_coprocessor_alu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [0:0]  issue_hartid_i;
  logic [3:0]  issue_id_i;
  logic        issue_accept_o;
  logic        issue_writeback_o;
  logic [1:0]  issue_register_read_o;
  logic        issue_ecswrite_o;
  logic        issue_loadstore_o;
  logic        register_valid_i;
  logic        register_ready_o;
  logic [0:0]  register_hartid_i;
  logic [3:0]  register_id_i;
  logic [31:0] register_rs0_i;
  logic [31:0] register_rs1_i;
  logic [1:0]  register_rs_valid_i;
  logic        commit_valid_i;
  logic [0:0]  commit_hartid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [0:0]  result_hartid_o;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [2:0]  result_ecswe_o;
  logic [5:0]  result_ecsdata_o;
  logic        result_exc_o;
  logic        result_dbg_o;
  logic        result_err_o;
  logic [5:0]  result_exccode_o;

  xif_coprocessor_alu dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_hartid_i(issue_hartid_i), .issue_id_i(issue_id_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .issue_register_read_o(issue_register_read_o), .issue_ecswrite_o(issue_ecswrite_o),
    .issue_loadstore_o(issue_loadstore_o),
    .register_valid_i(register_valid_i), .register_ready_o(register_ready_o),
    .register_hartid_i(register_hartid_i), .register_id_i(register_id_i),
    .register_rs0_i(register_rs0_i), .register_rs1_i(register_rs1_i),
    .register_rs_valid_i(register_rs_valid_i),
    .commit_valid_i(commit_valid_i), .commit_hartid_i(commit_hartid_i),
    .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_hartid_o(result_hartid_o), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .result_ecswe_o(result_ecswe_o), .result_ecsdata_o(result_ecsdata_o),
    .result_exc_o(result_exc_o), .result_dbg_o(result_dbg_o), .result_err_o(result_err_o),
    .result_exccode_o(result_exccode_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic        acc;
    logic [1:0]  rr;
  } dec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [3:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_t;

  dec_t dec [8];
  alu_t alu [5];

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] opc);
    return {17'd0, f3, rd, opc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i       = 1'b0;
    register_valid_i    = 1'b0;
    register_rs_valid_i = 2'b00;
    commit_valid_i      = 1'b0;
    commit_kill_i       = 1'b0;
  endtask

  task automatic drv_issue(input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] id);
    issue_valid_i  = 1'b1;
    issue_instr_i  = mk(f3, rd, 7'b0001011);
    issue_hartid_i = 1'b0;
    issue_id_i     = id;
  endtask

  task automatic drv_reg(input logic [3:0] id, input logic [31:0] a, input logic [31:0] b);
    register_valid_i    = 1'b1;
    register_hartid_i   = 1'b0;
    register_id_i       = id;
    register_rs0_i      = a;
    register_rs1_i      = b;
    register_rs_valid_i = 2'b11;
  endtask

  task automatic drv_commit(input logic [3:0] id, input logic kill);
    commit_valid_i  = 1'b1;
    commit_hartid_i = 1'b0;
    commit_id_i     = id;
    commit_kill_i   = kill;
  endtask

  task automatic check_result(input string name, input logic [3:0] id, input logic [4:0] rd,
                              input logic [31:0] data);
    check({name, ".valid"}, 32'(result_valid_o), 32'd1);
    check({name, ".id"},    32'(result_id_o),    32'(id));
    check({name, ".rd"},    32'(result_rd_o),    32'(rd));
    check({name, ".data"},  result_data_o,       data);
    check({name, ".we"},    32'(result_we_o),    32'd1);
    $display("result %s id=%0d rd=%0d data=%h", name, result_id_o, result_rd_o, result_data_o);
  endtask

  initial begin
    dec[0] = '{mk(3'b000, 5'd1, 7'b0001011), 1'b1, 2'b11};
    dec[1] = '{mk(3'b001, 5'd2, 7'b0001011), 1'b1, 2'b11};
    dec[2] = '{mk(3'b010, 5'd3, 7'b0001011), 1'b1, 2'b11};
    dec[3] = '{mk(3'b011, 5'd4, 7'b0001011), 1'b1, 2'b11};
    dec[4] = '{mk(3'b100, 5'd5, 7'b0001011), 1'b0, 2'b00};
    dec[5] = '{mk(3'b111, 5'd6, 7'b0001011), 1'b0, 2'b00};
    dec[6] = '{mk(3'b000, 5'd7, 7'b0110011), 1'b0, 2'b00};
    dec[7] = '{mk(3'b001, 5'd8, 7'b0001010), 1'b0, 2'b00};

    alu[0] = '{3'b000, 5'd5,  4'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    alu[1] = '{3'b001, 5'd6,  4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
    alu[2] = '{3'b010, 5'd7,  4'd5, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    alu[3] = '{3'b011, 5'd8,  4'd6, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608};
    alu[4] = '{3'b000, 5'd31, 4'd7, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};

    rst_i          = 1'b1;
    result_ready_i = 1'b0;
    issue_instr_i  = 32'd0;
    issue_hartid_i = 1'b0;
    issue_id_i     = 4'd0;
    register_hartid_i = 1'b0;
    register_id_i  = 4'd0;
    register_rs0_i = 32'd0;
    register_rs1_i = 32'd0;
    commit_hartid_i = 1'b0;
    commit_id_i    = 4'd0;
    idle();

    // Reset held two cycles
    tick();
    tick();
    check("rst.issue_ready", 32'(issue_ready_o), 32'd0);
    check("rst.reg_ready",   32'(register_ready_o), 32'd0);
    check("rst.result_valid", 32'(result_valid_o), 32'd0);

    // Decode table: issue_valid high while held in reset, so nothing allocates
    issue_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_instr_i = dec[i].instr;
      #1;
      check($sformatf("dec%0d.accept", i), 32'(issue_accept_o), 32'(dec[i].acc));
      check($sformatf("dec%0d.wb", i), 32'(issue_writeback_o), 32'(dec[i].acc));
      check($sformatf("dec%0d.rr", i), 32'(issue_register_read_o), 32'(dec[i].rr));
      check($sformatf("dec%0d.ls", i), 32'({issue_ecswrite_o, issue_loadstore_o}), 32'd0);
      $display("decode instr=%h accept=%0d rr=%b", issue_instr_i, issue_accept_o,
               issue_register_read_o);
    end
    idle();
    rst_i = 1'b0;
    #1;
    check("post_rst.issue_ready", 32'(issue_ready_o), 32'd1);
    check("post_rst.result_valid", 32'(result_valid_o), 32'd0);
    tick();

    // ALU table: issue, register and commit in the same cycle
    for (int i = 0; i < 5; i++) begin
      drv_issue(alu[i].f3, alu[i].rd, alu[i].id);
      drv_reg(alu[i].id, alu[i].a, alu[i].b);
      drv_commit(alu[i].id, 1'b0);
      tick();
      idle();
      check_result($sformatf("alu%0d", i), alu[i].id, alu[i].rd, alu[i].exp);
      tick();
      check($sformatf("alu%0d.hold_valid", i), 32'(result_valid_o), 32'd1);
      check($sformatf("alu%0d.hold_data", i), result_data_o, alu[i].exp);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      check($sformatf("alu%0d.popped", i), 32'(result_valid_o), 32'd0);
      check($sformatf("alu%0d.zero_data", i), result_data_o, 32'd0);
    end

    // Reject: standard OP opcode, with register and commit for the same id
    issue_valid_i  = 1'b1;
    issue_instr_i  = mk(3'b000, 5'd5, 7'b0110011);
    issue_id_i     = 4'd9;
    drv_reg(4'd9, 32'd1, 32'd2);
    drv_commit(4'd9, 1'b0);
    result_ready_i = 1'b1;
    #1;
    check("rej.accept", 32'(issue_accept_o), 32'd0);
    check("rej.rr", 32'(issue_register_read_o), 32'd0);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rej.no_result%0d", c), 32'(result_valid_o), 32'd0);
      tick();
    end
    result_ready_i = 1'b0;
    $display("reject id=9 produced no result");

    // Kill ordering: id1 (SUB) killed, id2 (XOR) committed
    drv_issue(3'b010, 5'd1, 4'd1);
    tick();
    idle();
    drv_issue(3'b001, 5'd2, 4'd2);
    drv_reg(4'd1, 32'd10, 32'd3);
    tick();
    idle();
    drv_commit(4'd1, 1'b1);
    drv_reg(4'd2, 32'h0000_00AA, 32'h0000_0055);
    tick();
    idle();
    check("kill.head_silent", 32'(result_valid_o), 32'd0);
    drv_commit(4'd2, 1'b0);
    tick();
    idle();
    check_result("kill.id2", 4'd2, 5'd2, 32'h0000_00FF);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("kill.drained", 32'(result_valid_o), 32'd0);

    // Full: four accepted, none committed
    for (int k = 0; k < 4; k++) begin
      check($sformatf("full.ready%0d", k), 32'(issue_ready_o), 32'd1);
      drv_issue(3'b000, 5'(10 + k), 4'(10 + k));
      drv_reg(4'(10 + k), 32'((10 + k) << 8), 32'd1);
      tick();
      idle();
    end
    check("full.not_ready", 32'(issue_ready_o), 32'd0);
    drv_issue(3'b000, 5'd15, 4'd15);
    tick();
    idle();
    check("full.still_not_ready", 32'(issue_ready_o), 32'd0);
    result_ready_i = 1'b1;
    drv_commit(4'd10, 1'b0);
    tick();
    idle();
    check_result("full.id10", 4'd10, 5'd10, 32'h0000_0A01);
    check("full.no_bypass", 32'(issue_ready_o), 32'd0);
    tick();
    check("full.ready_after_pop", 32'(issue_ready_o), 32'd1);
    check("full.head11_waits", 32'(result_valid_o), 32'd0);
    drv_issue(3'b000, 5'd14, 4'd14);
    drv_reg(4'd14, 32'h0000_0E00, 32'd1);
    tick();
    idle();
    check("full.wrap_full", 32'(issue_ready_o), 32'd0);
    for (int k = 11; k <= 14; k++) begin
      drv_commit(4'(k), 1'b0);
      tick();
      idle();
      check_result($sformatf("full.id%0d", k), 4'(k), 5'(k), 32'((k << 8) + 1));
    end
    tick();
    check("full.drained", 32'(result_valid_o), 32'd0);
    check("full.ready_empty", 32'(issue_ready_o), 32'd1);
    result_ready_i = 1'b0;

    // Out-of-order operands, in-order commits
    drv_issue(3'b011, 5'd3, 4'd1);
    tick();
    idle();
    drv_issue(3'b001, 5'd4, 4'd2);
    tick();
    idle();
    drv_reg(4'd2, 32'h0000_F0F0, 32'h0000_0FF0);
    tick();
    idle();
    drv_reg(4'd1, 32'hFF00_FF00, 32'h0FF0_0FF0);
    tick();
    idle();
    check("ooo.uncommitted", 32'(result_valid_o), 32'd0);
    result_ready_i = 1'b1;
    drv_commit(4'd1, 1'b0);
    tick();
    idle();
    check_result("ooo.id1", 4'd1, 5'd3, 32'h0F00_0F00);
    drv_commit(4'd2, 1'b0);
    tick();
    idle();
    check_result("ooo.id2", 4'd2, 5'd4, 32'h0000_FF00);
    tick();
    check("ooo.drained", 32'(result_valid_o), 32'd0);
    result_ready_i = 1'b0;

    // Reset while a result is pending discards it
    drv_issue(3'b000, 5'd9, 4'd7);
    drv_reg(4'd7, 32'd1, 32'd1);
    drv_commit(4'd7, 1'b0);
    tick();
    idle();
    check("rst_mid.pending", 32'(result_valid_o), 32'd1);
    rst_i = 1'b1;
    tick();
    check("rst_mid.valid", 32'(result_valid_o), 32'd0);
    check("rst_mid.issue_ready", 32'(issue_ready_o), 32'd0);
    check("rst_mid.reg_ready", 32'(register_ready_o), 32'd0);
    rst_i = 1'b0;
    tick();
    check("rst_mid.discarded", 32'(result_valid_o), 32'd0);
    check("rst_mid.ready_back", 32'(issue_ready_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
